// File: rtl/lmc_rx.sv
// Receive lane merge: de-stripes up to 16 lanes of descrambled symbols into one LSB-first byte stream.
// Optional LMC_SYNCHDR_CHECK_EN: in GEN3, a valid output also requires sync header 2'b01 or 2'b10.
module lmc_rx #(
   parameter int GEN1_PIPEWIDTH = 8,
   parameter int GEN2_PIPEWIDTH = 16,
   parameter int GEN3_PIPEWIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [2:0]   GEN,
   input  logic [4:0]   LANESNUMBER,
   input  logic [511:0] LMCIn,
   input  logic [63:0]  descramblerDataK,
   input  logic [15:0]  descramblerDataValid,
   input  logic [1:0]   descramblerSyncHeader,
   output logic [511:0] LMCData,
   output logic [63:0]  LMCDataK,
   output logic         LMCValid
);

   localparam int B1 = GEN1_PIPEWIDTH / 8;
   localparam int B2 = GEN2_PIPEWIDTH / 8;
   localparam int B3 = GEN3_PIPEWIDTH / 8;

   // One fully interleaved candidate per legal lane count (1,2,4,8,16), all four bytes per lane.
   logic [4:0][511:0] merged_data;
   logic [4:0][63:0]  merged_k;

   generate
      for (genvar gl = 0; gl < 5; gl++) begin : g_lanecount
         localparam int LC = 1 << gl;
         for (genvar gt = 0; gt < 4; gt++) begin : g_byte
            for (genvar gi = 0; gi < LC; gi++) begin : g_lane
               assign merged_data[gl][8*(gt*LC+gi) +: 8] = LMCIn[32*gi+8*gt +: 8];
               assign merged_k[gl][gt*LC+gi]              = descramblerDataK[4*gi+gt];
            end
         end
         if (LC < 16) begin : g_pad
            assign merged_data[gl][511:32*LC] = '0;
            assign merged_k[gl][63:4*LC]      = '0;
         end
      end
   endgenerate

   int          lanes_n;
   int          bytes_per_lane;
   int          n_bytes;
   logic [2:0]  lc_sel;
   logic        lanes_ok;
   logic        gen_ok;
   logic        hdr_ok;
   logic [15:0] lane_mask;
   logic [511:0] data_next, data_reg;
   logic [63:0]  k_next, k_reg;
   logic         valid_next, valid_reg;

`ifndef LMC_SYNCHDR_CHECK_EN
   logic unused_hdr;
   assign unused_hdr = ^descramblerSyncHeader;
`endif

   always_comb begin
      lanes_n        = {27'd0, LANESNUMBER};
      lanes_ok       = 1'b1;
      lc_sel         = 3'd0;
      gen_ok         = 1'b1;
      bytes_per_lane = 0;
      lane_mask      = '0;
      data_next      = '0;
      k_next         = '0;
      valid_next     = 1'b0;

      case (LANESNUMBER)
         5'd1:    lc_sel = 3'd0;
         5'd2:    lc_sel = 3'd1;
         5'd4:    lc_sel = 3'd2;
         5'd8:    lc_sel = 3'd3;
         5'd16:   lc_sel = 3'd4;
         default: lanes_ok = 1'b0;
      endcase

      case (GEN)
         3'd1:    bytes_per_lane = B1;
         3'd2:    bytes_per_lane = B2;
         3'd3:    bytes_per_lane = B3;
         default: gen_ok = 1'b0;
      endcase

      n_bytes = lanes_n * bytes_per_lane;

      for (int i = 0; i < 16; i++) begin
         lane_mask[i] = (i < lanes_n);
      end

`ifdef LMC_SYNCHDR_CHECK_EN
      hdr_ok = (GEN != 3'd3) || (descramblerSyncHeader == 2'b01) || (descramblerSyncHeader == 2'b10);
`else
      hdr_ok = 1'b1;
`endif

      // Bytes beyond L*B belong to unused byte slots of the candidate and are forced to zero.
      if (lanes_ok && gen_ok) begin
         for (int k = 0; k < 64; k++) begin
            if (k < n_bytes) begin
               data_next[8*k +: 8] = merged_data[lc_sel][8*k +: 8];
               k_next[k]           = merged_k[lc_sel][k];
            end
         end
         valid_next = hdr_ok && (&(descramblerDataValid | ~lane_mask));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         data_reg  <= '0;
         k_reg     <= '0;
         valid_reg <= 1'b0;
      end else begin
         data_reg  <= data_next;
         k_reg     <= k_next;
         valid_reg <= valid_next;
      end
   end

   assign LMCData  = data_reg;
   assign LMCDataK = k_reg;
   assign LMCValid = valid_reg;

endmodule

// File: tb/tb_lmc_rx.sv
// Scoreboard bench for lmc_rx: stimulus pushes expected results, a monitor compares one cycle later.
// Honours LMC_SYNCHDR_CHECK_EN the same way as the design build.
module tb_lmc_rx;

   logic         clk;
   logic         reset;
   logic [2:0]   GEN;
   logic [4:0]   LANESNUMBER;
   logic [511:0] LMCIn;
   logic [63:0]  descramblerDataK;
   logic [15:0]  descramblerDataValid;
   logic [1:0]   descramblerSyncHeader;
   logic [511:0] LMCData;
   logic [63:0]  LMCDataK;
   logic         LMCValid;

   int checks = 0;
   int passes = 0;

   logic [511:0] exp_d_q[$];
   logic [63:0]  exp_k_q[$];
   logic         exp_v_q[$];
   string        tag_q[$];

   lmc_rx dut (
      .clk(clk),
      .reset(reset),
      .GEN(GEN),
      .LANESNUMBER(LANESNUMBER),
      .LMCIn(LMCIn),
      .descramblerDataK(descramblerDataK),
      .descramblerDataValid(descramblerDataValid),
      .descramblerSyncHeader(descramblerSyncHeader),
      .LMCData(LMCData),
      .LMCDataK(LMCDataK),
      .LMCValid(LMCValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   // Reference: walk the output byte index k and find its source lane k%L, byte k/L.
   task automatic model(input logic rst_n, input logic [2:0] g, input logic [4:0] l,
                        input logic [511:0] din, input logic [63:0] kin, input logic [15:0] vin,
                        input logic [1:0] hdr, output logic [511:0] d, output logic [63:0] k,
                        output logic v);
      int bpl;
      int nl;
      d = '0;
      k = '0;
      v = 1'b0;
      bpl = (g == 3'd1) ? 1 : (g == 3'd2) ? 2 : (g == 3'd3) ? 4 : 0;
      nl = int'(l);
      if (rst_n && bpl != 0 && (nl == 1 || nl == 2 || nl == 4 || nl == 8 || nl == 16)) begin
         for (int kk = 0; kk < nl * bpl; kk++) begin
            d[8*kk +: 8] = din[32*(kk % nl) + 8*(kk / nl) +: 8];
            k[kk]        = kin[4*(kk % nl) + (kk / nl)];
         end
         v = 1'b1;
         for (int i = 0; i < nl; i++) v = v & vin[i];
`ifdef LMC_SYNCHDR_CHECK_EN
         if (g == 3'd3 && (hdr == 2'b00 || hdr == 2'b11)) v = 1'b0;
`endif
      end
   endtask

   task automatic drive(input logic rst_n, input logic [2:0] g, input logic [4:0] l,
                        input logic [511:0] din, input logic [63:0] kin, input logic [15:0] vin,
                        input logic [1:0] hdr);
      @(negedge clk);
      reset                 = rst_n;
      GEN                   = g;
      LANESNUMBER           = l;
      LMCIn                 = din;
      descramblerDataK      = kin;
      descramblerDataValid  = vin;
      descramblerSyncHeader = hdr;
   endtask

   task automatic push_exp(input logic [511:0] d, input logic [63:0] k, input logic v, input string tag);
      exp_d_q.push_back(d);
      exp_k_q.push_back(k);
      exp_v_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic push_model(input string tag);
      logic [511:0] d;
      logic [63:0]  k;
      logic         v;
      model(reset, GEN, LANESNUMBER, LMCIn, descramblerDataK, descramblerDataValid,
            descramblerSyncHeader, d, k, v);
      push_exp(d, k, v, tag);
   endtask

   // Monitor: one registered result per clock, checked just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_d_q.size() > 0) begin
            logic [511:0] ed;
            logic [63:0]  ek;
            logic         ev;
            string        t;
            ed = exp_d_q.pop_front();
            ek = exp_k_q.pop_front();
            ev = exp_v_q.pop_front();
            t  = tag_q.pop_front();
            checks++;
            if (LMCData !== ed) $display("FAIL %s data got=%h exp=%h", t, LMCData, ed);
            else passes++;
            checks++;
            if (LMCDataK !== ek) $display("FAIL %s dataK got=%h exp=%h", t, LMCDataK, ek);
            else passes++;
            checks++;
            if (LMCValid !== ev) $display("FAIL %s valid got=%b exp=%b", t, LMCValid, ev);
            else passes++;
            $display("txn %-8s gen=%0d lanes=%0d valid=%b data[63:0]=%h", t, GEN, LANESNUMBER, LMCValid, LMCData[63:0]);
         end
      end
   end

   initial begin
      logic [511:0] base;
      logic [63:0]  kbase;
      logic [511:0] d;
      logic [63:0]  k;
      logic         v;
      logic [4:0]   lanes_tbl[5];
      lanes_tbl[0] = 5'd1; lanes_tbl[1] = 5'd2; lanes_tbl[2] = 5'd4;
      lanes_tbl[3] = 5'd8; lanes_tbl[4] = 5'd16;

      reset = 1'b0; GEN = 3'd1; LANESNUMBER = 5'd1; LMCIn = '0;
      descramblerDataK = '0; descramblerDataValid = '1; descramblerSyncHeader = 2'b01;

      base = rand512();
      base[31:0]  = 32'h16202D3A;
      base[63:32] = 32'h15192C2F;
      kbase = {$urandom, $urandom};
      kbase[7:0] = 8'b0011_1000;

      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 3'd3, 5'd16, rand512(), {$urandom, $urandom}, 16'hFFFF, 2'b01);
         push_exp('0, '0, 1'b0, "reset");
      end

      drive(1'b1, 3'd1, 5'd1, base, kbase, 16'hFFFF, 2'b01);
      push_exp(512'h3A, 64'h0, 1'b1, "g1l1");
      drive(1'b1, 3'd1, 5'd2, base, kbase, 16'hFFFF, 2'b01);
      push_exp(512'h2F3A, 64'h2, 1'b1, "g1l2");
      drive(1'b1, 3'd2, 5'd2, base, kbase, 16'hFFFF, 2'b01);
      push_exp(512'h2C2D2F3A, 64'hA, 1'b1, "g2l2");
      drive(1'b1, 3'd3, 5'd16, rand512(), {$urandom, $urandom}, 16'hFFFF, 2'b01);
      push_model("g3l16");

      drive(1'b1, 3'd2, 5'd4, base, kbase, 16'hFFF7, 2'b01);
      model(1'b1, 3'd2, 5'd4, base, kbase, 16'hFFFF, 2'b01, d, k, v);
      push_exp(d, k, 1'b0, "vmask4");
      drive(1'b1, 3'd2, 5'd2, base, kbase, 16'hFFF7, 2'b01);
      push_exp(512'h2C2D2F3A, 64'hA, 1'b1, "vmask2");
      drive(1'b1, 3'd2, 5'd3, base, kbase, 16'hFFFF, 2'b01);
      push_exp('0, '0, 1'b0, "lanes3");
      drive(1'b1, 3'd0, 5'd4, base, kbase, 16'hFFFF, 2'b01);
      push_exp('0, '0, 1'b0, "gen0");

      drive(1'b0, 3'd3, 5'd8, rand512(), {$urandom, $urandom}, 16'hFFFF, 2'b10);
      push_exp('0, '0, 1'b0, "midrst");
      drive(1'b1, 3'd3, 5'd8, rand512(), {$urandom, $urandom}, 16'hFFFF, 2'b10);
      push_model("release");

`ifdef LMC_SYNCHDR_CHECK_EN
      drive(1'b1, 3'd3, 5'd4, base, kbase, 16'hFFFF, 2'b00);
      model(1'b1, 3'd3, 5'd4, base, kbase, 16'hFFFF, 2'b01, d, k, v);
      push_exp(d, k, 1'b0, "hdr00");
      drive(1'b1, 3'd3, 5'd4, base, kbase, 16'hFFFF, 2'b10);
      push_exp(d, k, 1'b1, "hdr10");
      drive(1'b1, 3'd2, 5'd2, base, kbase, 16'hFFFF, 2'b00);
      push_exp(512'h2C2D2F3A, 64'hA, 1'b1, "g2hdr00");
`endif

      for (int c = 0; c < 400; c++) begin
         logic       rst_n;
         logic [2:0] g;
         logic [4:0] l;
         logic [15:0] vin;
         int r;
         rst_n = ($urandom_range(0, 39) != 0);
         r = $urandom_range(0, 9);
         g = (r < 8) ? 3'(1 + r % 3) : 3'($urandom_range(0, 7));
         l = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : lanes_tbl[$urandom_range(0, 4)];
         vin = ($urandom_range(0, 9) < 7) ? 16'hFFFF : ~(16'h1 << $urandom_range(0, 15));
         drive(rst_n, g, l, rand512(), {$urandom, $urandom}, vin, 2'($urandom_range(0, 3)));
         push_model("rand");
      end

      for (int w = 0; w < 10 && exp_d_q.size() != 0; w++) @(negedge clk);
      @(negedge clk);
      if (exp_d_q.size() != 0) begin
         checks++;
         $display("FAIL drain pending=%0d required=0", exp_d_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
